// File: rtl/tri_voice_if.sv
// Register-write bus into the triangle voice: one-cycle strobe, 2-bit select, 8-bit data.
interface tri_voice_if;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 8;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/tri_voice.sv
// Triangle voice: period timer, linear and length counters gating a folded step sequencer.
module tri_voice #(
    parameter int unsigned TIMER_W    = 11,
    parameter int unsigned STEP_W     = 5,
    parameter int unsigned MIN_PERIOD = 2
) (
    input  logic              clk,
    input  logic              reset,
    tri_voice_if.slave        bus,
    input  logic              enable,
    input  logic              qtr_frame,
    input  logic              half_frame,
    output logic [STEP_W-2:0] y,
    output logic              active
);
    localparam int unsigned HI_W  = TIMER_W - 8;
    localparam int unsigned Y_W   = STEP_W - 1;
    localparam int unsigned LEN_W = 8;
    localparam int unsigned LIN_W = 7;

    localparam logic [LEN_W-1:0] LEN_TABLE [32] = '{
        8'd10,  8'd254, 8'd20, 8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
        8'd160, 8'd8,   8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
        8'd12,  8'd16,  8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
        8'd192, 8'd24,  8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
    };

    logic               ctrl;
    logic [LIN_W-1:0]   lin_rld;
    logic [TIMER_W-1:0] period;
    logic [TIMER_W-1:0] timer;
    logic [STEP_W-1:0]  step;
    logic [LEN_W-1:0]   len_cnt;
    logic [LIN_W-1:0]   lin_cnt;
    logic               reload;

    logic wr0, wr2, wr3;
    logic tick;
    logic step_run;

    always_comb begin
        wr0      = bus.wr_en && (bus.wr_addr == 2'd0);
        wr2      = bus.wr_en && (bus.wr_addr == 2'd2);
        wr3      = bus.wr_en && (bus.wr_addr == 2'd3);
        tick     = (timer == '0);
        step_run = tick && (lin_cnt != '0) && (len_cnt != '0)
                   && (period >= TIMER_W'(MIN_PERIOD));
    end

    // Register file; new values only take effect from the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl    <= 1'b0;
            lin_rld <= '0;
            period  <= '0;
        end else begin
            if (wr0) begin
                ctrl    <= bus.wr_data[7];
                lin_rld <= bus.wr_data[LIN_W-1:0];
            end
            if (wr2) begin
                period[7:0] <= bus.wr_data;
            end
            if (wr3) begin
                period[TIMER_W-1:8] <= bus.wr_data[HI_W-1:0];
            end
        end
    end

    // Period timer and step sequencer; ultrasonic periods freeze the step.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
            step  <= '0;
        end else begin
            timer <= tick ? period : timer - TIMER_W'(1);
            if (step_run) begin
                step <= step + STEP_W'(1);
            end
        end
    end

    // Linear counter; an addr3 write re-arms the reload even when a quarter frame clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            lin_cnt <= '0;
            reload  <= 1'b0;
        end else begin
            if (qtr_frame) begin
                if (reload) begin
                    lin_cnt <= lin_rld;
                end else if (lin_cnt != '0) begin
                    lin_cnt <= lin_cnt - LIN_W'(1);
                end
                if (!ctrl) begin
                    reload <= 1'b0;
                end
            end
            if (wr3) begin
                reload <= 1'b1;
            end
        end
    end

    // Length counter; a table load beats a coincident half-frame decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_cnt <= '0;
        end else if (!enable) begin
            len_cnt <= '0;
        end else if (wr3) begin
            len_cnt <= LEN_TABLE[bus.wr_data[7:3]];
        end else if (half_frame && !ctrl && (len_cnt != '0)) begin
            len_cnt <= len_cnt - LEN_W'(1);
        end
    end

    always_comb begin
        y      = ~(step[Y_W-1:0] ^ {Y_W{step[STEP_W-1]}});
        active = (len_cnt != '0);
    end
endmodule

// File: doc/tri_voice.md
TRI_VOICE -- requirements
Module: tri_voice

Interface
REQ-001 SHALL have parameter TIMER_W, default 11, meaning period/timer width (legal 9..11).
REQ-002 SHALL have parameter STEP_W, default 5, meaning step-generator width; output width is STEP_W-1.
REQ-003 SHALL have parameter MIN_PERIOD, default 2, meaning the period below which stepping is frozen (ultrasonic mute).
REQ-004 SHALL have port clk  input  1  clock, one tick per APU cycle.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  register write strobe, one cycle.
REQ-007 SHALL have port wr_addr  input  2  register select: 0 = control/linear, 2 = period LSB, 3 = length/period MSB; 1 = ignored.
REQ-008 SHALL have port wr_data  input  8  register write data.
REQ-009 SHALL have port enable  input  1  channel enable (status bit), level.
REQ-010 SHALL have port qtr_frame  input  1  quarter-frame pulse, one cycle.
REQ-011 SHALL have port half_frame  input  1  half-frame pulse, one cycle.
REQ-012 SHALL have port y  output  STEP_W-1  triangle sample.
REQ-013 SHALL have port active  output  1  high when length counter is non-zero.

Function
REQ-014 SHALL hold registers: ctrl (1 bit, addr0 bit7 = control/halt flag), lin_rld (7 bits, addr0 bits6:0), period (TIMER_W bits: addr2 -> bits7:0, addr3 bits(TIMER_W-9):0 -> upper bits).
REQ-015 SHALL make register writes visible from the cycle after wr_en; same-cycle frame events use pre-write values, except where REQ-021 states otherwise.
REQ-016 SHALL run timer as a TIMER_W-bit down counter: at 0 reload period and assert internal tick for that cycle, else decrement; period = 0 gives a tick every cycle.
REQ-017 SHALL advance step (STEP_W-bit, wraps max->0) on tick only when lin_cnt != 0 AND len_cnt != 0 AND period >= MIN_PERIOD; otherwise step holds.
REQ-018 SHALL drive y[i] = NOT(step[i] XOR step[STEP_W-1]), so y counts max..0 then 0..max; a frozen step holds y at its last value (no return to zero).
REQ-019 SHALL implement lin_cnt (7 bits) with a reload flag: on qtr_frame, if flag then lin_cnt <= lin_rld, else if lin_cnt != 0 then decrement; after this, flag clears if ctrl = 0.
REQ-020 SHALL set the reload flag on any addr3 write.
REQ-021 SHALL, on addr3 write with enable = 1, load len_cnt from a 32-entry table indexed by wr_data[7:3]: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30; the load wins over a same-cycle half_frame decrement.
REQ-022 SHALL, on half_frame, decrement len_cnt if ctrl = 0 and len_cnt != 0; len_cnt never wraps below 0.
REQ-023 SHALL force len_cnt to 0 every cycle enable = 0 and ignore length loads during that time.
REQ-024 SHALL evaluate qtr_frame and half_frame independently when both are high in the same cycle.
REQ-025 SHALL drive active = (len_cnt != 0), combinationally from the register.

Reset
REQ-026 SHALL, on reset, clear timer, step, len_cnt, lin_cnt, reload flag, ctrl, lin_rld, and period to 0, giving y = all ones (15 at default) and active = 0.
REQ-027 SHALL let reset override all writes and frame pulses in the same cycle, including mid-waveform.

Verification
REQ-028 SHALL cover: enable=1, write addr0=0x81, addr2=0x04, addr3=0x08, one qtr_frame -> lin_cnt=1, len_cnt=254, active=1, step advances every 5 clk, y sequence 15,14,...,0,0,1,...
REQ-029 SHALL cover: addr3 index 1 with ctrl=0, 254 half_frames -> active falls exactly on the 254th; y frozen at its value from that point.
REQ-030 SHALL cover: period=1 (< MIN_PERIOD) with counters non-zero -> ticks occur, step never changes.
REQ-031 SHALL cover: addr3 write coincident with half_frame, ctrl=0 -> len_cnt equals table value, not value-1.
REQ-032 SHALL cover: enable dropped mid-note -> active=0 next cycle; addr3 write while enable=0 -> active stays 0.
REQ-033 SHALL cover: reset asserted mid-waveform with wr_en high -> next cycle y=15, active=0, all registers 0.
